// File: rtl/piano_pkg.sv
// Shared constants, note table and helpers for the piano key front end.
// NOTE_HALF[k] is the half-period count (minus one) for note k, C4..D#5.
package piano_pkg;

    localparam int unsigned NUM_KEYS = 16;
    localparam int unsigned KEY_W    = $clog2(NUM_KEYS);
    localparam int unsigned FREQ_W   = 18;
    localparam int unsigned CLK_HZ   = 100_000_000;

    localparam logic [FREQ_W-1:0] NOTE_HALF [NUM_KEYS] = '{
        18'd191112, 18'd180385, 18'd170261, 18'd160705,
        18'd151685, 18'd143172, 18'd135136, 18'd127552,
        18'd120393, 18'd113635, 18'd107257, 18'd101237,
        18'd95555,  18'd90192,  18'd85130,  18'd80352
    };

    typedef enum logic [1:0] {IDLE, PLAY, GAP} arb_state_t;

    function automatic logic [KEY_W-1:0] highestIndex(input logic [NUM_KEYS-1:0] v);
        highestIndex = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) highestIndex = KEY_W'(i);
        end
    endfunction

    function automatic logic [NUM_KEYS-1:0] oneHot(input logic [KEY_W-1:0] k);
        oneHot    = '0;
        oneHot[k] = 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus tick-sampled debounce for a vector of key switches.
// A bit follows the input only when two consecutive tick samples agree.
module key_debounce
    import piano_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 100,
    parameter int unsigned WIDTH           = NUM_KEYS
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] keys,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] pressEdge,
    output logic [WIDTH-1:0] releaseEdge
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] syncA;
    logic [WIDTH-1:0] syncB;
    logic [WIDTH-1:0] lastSample;
    logic [WIDTH-1:0] agree;
    logic [WIDTH-1:0] nextDeb;
    logic [CNT_W-1:0] sampleCnt;
    logic             tick;

    assign tick = (sampleCnt == CNT_LAST);

    always_comb begin
        agree   = ~(syncB ^ lastSample);
        nextDeb = (syncB & agree) | (debounced & ~agree);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            syncA       <= '0;
            syncB       <= '0;
            lastSample  <= '0;
            sampleCnt   <= '0;
            debounced   <= '0;
            pressEdge   <= '0;
            releaseEdge <= '0;
        end else begin
            syncA     <= keys;
            syncB     <= syncA;
            sampleCnt <= tick ? '0 : sampleCnt + 1'b1;
            if (tick) begin
                lastSample  <= syncB;
                debounced   <= nextDeb;
                pressEdge   <= nextDeb & ~debounced;
                releaseEdge <= ~nextDeb & debounced;
            end else begin
                pressEdge   <= '0;
                releaseEdge <= '0;
            end
        end
    end

endmodule

// File: rtl/key_tone_arbiter.sv
// Monophonic last-press-wins key arbiter driving the square-wave tone generator,
// with a muted gap between different notes so each change is articulated.
module key_tone_arbiter
    import piano_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 100,
    parameter int unsigned GAP_CYCLES      = CLK_HZ / 200
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] tone_gate,
    output logic [FREQ_W-1:0]   freq_val,
    output logic [KEY_W-1:0]    active_key,
    output logic                note_start
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [NUM_KEYS-1:0] debounced;
    logic [NUM_KEYS-1:0] pressEdge;
    logic [NUM_KEYS-1:0] releaseEdge;
    logic [KEY_W-1:0]    target;
    logic [KEY_W-1:0]    nextTarget;
    logic [GAP_W-1:0]    gapCnt;
    arb_state_t          state;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .WIDTH          (NUM_KEYS)
    ) u_debounce (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .keys       (keys),
        .debounced  (debounced),
        .pressEdge  (pressEdge),
        .releaseEdge(releaseEdge)
    );

    // A fresh press always outranks the fallback caused by releasing the target.
    always_comb begin
        nextTarget = target;
        if (|pressEdge) begin
            nextTarget = highestIndex(pressEdge);
        end else if (releaseEdge[target] && (|debounced)) begin
            nextTarget = highestIndex(debounced);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state      <= IDLE;
            target     <= '0;
            gapCnt     <= '0;
            tone_gate  <= '0;
            freq_val   <= '0;
            active_key <= '0;
            note_start <= 1'b0;
        end else begin
            target     <= nextTarget;
            note_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|pressEdge) begin
                        state      <= PLAY;
                        tone_gate  <= oneHot(nextTarget);
                        freq_val   <= NOTE_HALF[nextTarget];
                        active_key <= nextTarget;
                        note_start <= 1'b1;
                    end
                end
                PLAY: begin
                    if (!(|debounced)) begin
                        state     <= IDLE;
                        tone_gate <= '0;
                    end else if (nextTarget != target) begin
                        state     <= GAP;
                        tone_gate <= '0;
                        gapCnt    <= GAP_LAST;
                    end
                end
                GAP: begin
                    // Releasing everything takes priority over the gap expiring.
                    if (!(|debounced)) begin
                        state <= IDLE;
                    end else if (gapCnt == '0) begin
                        state      <= PLAY;
                        tone_gate  <= oneHot(nextTarget);
                        freq_val   <= NOTE_HALF[nextTarget];
                        active_key <= nextTarget;
                        note_start <= 1'b1;
                    end else begin
                        gapCnt <= gapCnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_tone_arbiter.sv
// Self-checking bench for key_tone_arbiter: behavioural model compared every
// cycle, plus literal checks of note table values and gap lengths.
module tb_key_tone_arbiter;

    localparam int DEB  = 4;
    localparam int GAPC = 8;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [15:0] keys;
    logic [15:0] tone_gate;
    logic [17:0] freq_val;
    logic [3:0]  active_key;
    logic        note_start;

    int errors   = 0;
    int checks   = 0;
    int nsCount  = 0;
    bit checking = 1'b0;

    key_tone_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .GAP_CYCLES     (GAPC)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .keys      (keys),
        .tone_gate (tone_gate),
        .freq_val  (freq_val),
        .active_key(active_key),
        .note_start(note_start)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int noteHalf(input int k);
        real f;
        f = 440.0 * (2.0 ** ((k - 9) / 12.0));
        return $rtoi(100.0e6 / (2.0 * f) + 0.5) - 1;
    endfunction

    function automatic int topKey(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // ---------------- behavioural model ----------------
    // Stages are evaluated back to front so each sees the previous cycle's values.
    logic [15:0] mSync1, mSync2, mPrevSamp, mDb, mPress, mRel;
    int          mPhase, mMode, mMuteLeft, mTarget, nt;
    logic [15:0] eGate;
    int          eFreq, eKey;
    logic        eStart;

    task automatic sound(input int k);
        eGate  = 16'(1) << k;
        eFreq  = noteHalf(k);
        eKey   = k;
        eStart = 1'b1;
        mMode  = 1;
    endtask

    always @(posedge CLK) begin
        if (!RSTN) begin
            mSync1 = '0; mSync2 = '0; mPrevSamp = '0; mDb = '0; mPress = '0; mRel = '0;
            mPhase = 0; mMode = 0; mMuteLeft = 0; mTarget = 0;
            eGate = '0; eFreq = 0; eKey = 0; eStart = 1'b0;
        end else begin
            eStart = 1'b0;
            nt = mTarget;
            if (mPress != 0) nt = topKey(mPress);
            else if (mRel[mTarget] && mDb != 0) nt = topKey(mDb);
            case (mMode)
                0: if (mPress != 0) sound(nt);
                1: begin
                    if (mDb == 0) begin
                        eGate = '0; mMode = 0;
                    end else if (nt != mTarget) begin
                        eGate = '0; mMode = 2; mMuteLeft = GAPC;
                    end
                end
                default: begin
                    if (mDb == 0) mMode = 0;
                    else begin
                        mMuteLeft--;
                        if (mMuteLeft == 0) sound(nt);
                    end
                end
            endcase
            mTarget = nt;

            mPress = '0;
            mRel   = '0;
            if (mPhase == DEB - 1) begin
                for (int k = 0; k < 16; k++) begin
                    if (mSync2[k] == mPrevSamp[k] && mDb[k] != mSync2[k]) begin
                        if (mSync2[k]) mPress[k] = 1'b1;
                        else           mRel[k]   = 1'b1;
                        mDb[k] = mSync2[k];
                    end
                end
                mPrevSamp = mSync2;
            end
            mPhase = (mPhase + 1) % DEB;
            mSync2 = mSync1;
            mSync1 = keys;
        end
    end

    always @(negedge CLK) begin
        if (checking) begin
            check("gate", tone_gate, eGate);
            check("freq", freq_val, eFreq);
            check("start", note_start, eStart);
            if (eGate != 0) check("key", active_key, eKey);
            if (note_start === 1'b1) nsCount++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic checkNote(input string tag, input int k, input int f);
        check({tag, "_start"}, note_start, 1);
        check({tag, "_gate"}, tone_gate, 32'(16'(1) << k));
        check({tag, "_freq"}, freq_val, f);
        check({tag, "_key"}, active_key, k);
    endtask

    task automatic waitNote(input string tag, input int k, input int f);
        int n = 0;
        while (note_start !== 1'b1 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        checkNote(tag, k, f);
    endtask

    task automatic measureGap(input string tag, input int k, input int f);
        int w = 0;
        int len = 0;
        while (tone_gate != 0 && w < 40) begin
            @(negedge CLK);
            w++;
        end
        while (tone_gate == 0 && len < 40) begin
            len++;
            @(negedge CLK);
        end
        check({tag, "_gaplen"}, len, GAPC);
        checkNote(tag, k, f);
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_gate"}, tone_gate, 0);
        check({tag, "_freq"}, freq_val, 0);
        check({tag, "_key"}, active_key, 0);
        check({tag, "_start"}, note_start, 0);
    endtask

    initial begin
        int base;
        int w;
        keys = '0;
        RSTN = 1'b0;
        @(negedge CLK);
        checking = 1'b1;
        cycles(2);
        checkReset("rst");
        RSTN = 1'b1;

        // First note from idle, no gap
        keys = 16'h0001;
        waitNote("k0", 0, 191112);
        @(negedge CLK);
        check("k0_pulse_once", note_start, 0);

        // Last press wins across a gap
        keys = 16'h0201;
        measureGap("k9", 9, 113635);

        // Fallback to highest held key after releasing the target
        keys = 16'h0000;
        cycles(20);
        keys = 16'h0010;
        waitNote("k4", 4, 151685);
        keys = 16'h0210;
        measureGap("k9b", 9, 113635);
        keys = 16'h0010;
        measureGap("k4b", 4, 151685);
        keys = 16'h0000;
        w = 0;
        while (tone_gate != 0 && w < 30) begin
            @(negedge CLK);
            w++;
        end
        check("idle_gate", tone_gate, 0);
        check("idle_freq_hold", freq_val, 151685);
        base = nsCount;
        cycles(15);
        check("idle_no_start", nsCount - base, 0);

        // Simultaneous presses: highest index wins; short glitch ignored
        keys = 16'h1008;
        waitNote("k12", 12, 95555);
        cycles(4);
        base = nsCount;
        keys = 16'h1028;
        cycles(1);
        keys = 16'h1008;
        cycles(20);
        check("glitch_no_start", nsCount - base, 0);
        check("glitch_gate", tone_gate, 32'h1000);

        // Press during a gap retargets without restarting it
        keys = 16'h100C;
        cycles(4);
        keys = 16'h108C;
        measureGap("k7", 7, 127552);

        // Release everything during a gap: back to idle without a note
        cycles(4);
        keys = 16'h100C;
        cycles(4);
        keys = 16'h0000;
        base = nsCount;
        cycles(30);
        check("gaprel_no_start", nsCount - base, 0);
        check("gaprel_gate", tone_gate, 0);

        // Reset mid-note mutes at once; held key replays as a fresh press
        keys = 16'h0040;
        waitNote("k6", 6, 135136);
        cycles(3);
        RSTN = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        checkReset("midrst");
        waitNote("k6r", 6, 135136);
        cycles(5);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/key_tone_arbiter.md
Name: key_tone_arbiter

Overview:
- Sits between the 16 piano key switches and the square-wave tone generator, which takes `sw[15:0]` and `freqVal[17:0]`.
- Debounces the keys and arbitrates them monophonically: the last-pressed key wins, with fallback to the highest held key.
- Drives the generator's gate vector and half-period count.
- Inserts a short muted gap on every note change so that successive notes are audibly articulated.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, CLK cycles between key samples (10 ms at 100 MHz). Bench uses 4.
- GAP_CYCLES, 500_000, muted cycles inserted between two different notes (5 ms). Bench uses 8.

Ports:
- CLK  in  1  100 MHz system clock.
- RSTN  in  1  synchronous active-low reset.
- keys  in  16  raw asynchronous key switches; bit k = note k.
- tone_gate  out  16  one-hot active key, or 0 when muted; drives generator `sw`.
- freq_val  out  18  half-period count of the active note; drives generator `freqVal`.
- active_key  out  4  index of the sounding note; valid while tone_gate != 0.
- note_start  out  1  one-cycle pulse in the first cycle a note begins sounding.

Behaviour:
- Reset (RSTN=0 at a CLK edge): tone_gate=0, freq_val=0, active_key=0, note_start=0. Debounced vector, sample counter, gap counter and target are cleared; FSM goes to IDLE. A reset asserted mid-note mutes on the next edge. Keys still held after reset release are treated as fresh presses once debounced.
- Synchroniser: keys pass through 2 flops before use.
- Debounce:
  - A free-running tick fires once every DEBOUNCE_CYCLES.
  - On each tick, a key's debounced bit takes the synchronised value only if the two most recent tick samples agree.
  - Press edge = debounced 0->1; release edge = 1->0. Both are single-cycle signals.
- Target selection (target register, 4 bits):
  - Any press edge: target = index of the pressed key. If several keys have press edges in the same cycle, the highest index wins.
  - Release edge of target while other keys are held: target = highest-index held key.
  - A press and the target's release in the same cycle: the press rule wins.
- FSM states: IDLE, PLAY, GAP. All outputs are registered.
  - IDLE: tone_gate=0. Any press edge -> PLAY with the new target. In the next cycle, tone_gate=1<<target, freq_val=NOTE_HALF[target], note_start=1. Latency is 1 cycle from the press edge; no gap is inserted from IDLE.
  - PLAY, target changes to a different key -> GAP. tone_gate=0 the next cycle; gap counter loads GAP_CYCLES-1.
  - PLAY, re-press of the same key: no change.
  - PLAY, all debounced keys released -> IDLE. tone_gate=0 the next cycle; no gap.
  - GAP: counter decrements. Presses during GAP only update target; the counter is not restarted.
    - All keys released during GAP -> IDLE.
    - Counter reaches 0 -> PLAY with the current target, with note_start=1.
    - Mute lasts exactly GAP_CYCLES cycles.
  - freq_val holds its last value while muted; it updates only on entry to PLAY.
- Frequency table:
  - NOTE_HALF[k] = round(100e6 / (2*f_k)) - 1, with f_k = 440 * 2^((k-9)/12), k=0..15 (C4..D#5).
  - This matches the generator's toggle-at-count>=freqVal rule (half period = freqVal+1 cycles).
  - All entries must fit in 18 bits; the maximum is C4 = 191112.
  - Example: k=9 (A4) = 113635.
- Counters: the sample counter and gap counter are sized with $clog2 of their parameter. A parameter value of 1 is legal: a tick every cycle, or a one-cycle gap.

Decomposition:
- Package piano_pkg holds:
  - NUM_KEYS=16, FREQ_W=18, CLK_HZ=100_000_000.
  - NOTE_HALF constant array [16][18].
  - typedef enum {IDLE, PLAY, GAP} arb_state_t.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES, width NUM_KEYS) contains the synchroniser, sample tick and agreement logic. It outputs the debounced vector plus per-key press/release edge vectors.
- key_tone_arbiter instantiates key_debounce and contains the target logic, FSM and output registers.

Test Plan:
- Reset with keys=0, then press key 0 and hold past 2 debounce ticks -> one cycle after the press edge: tone_gate=16'h0001, freq_val=191112, active_key=0, note_start pulses once.
- Key 0 held, press key 9 -> tone_gate=0 for exactly 8 cycles, then tone_gate=16'h0200, freq_val=113635, note_start=1 for one cycle.
- Keys 9 and 4 held, release key 9 -> 8-cycle gap, then key 4 plays. Then release key 4 -> tone_gate=0 the next cycle, FSM in IDLE, no gap, freq_val holds NOTE_HALF[4].
- Keys 3 and 12 pressed in the same cycle from IDLE -> key 12 plays. Toggle key 5 for 1 cycle only (shorter than a tick) -> no change.
- During a GAP toward key 2, press key 7 -> the gap still ends at the original time and key 7 plays. Separately, release all keys during a GAP -> IDLE with no note_start.
- Deassert RSTN mid-note for 1 cycle while key 6 is held -> all outputs 0 the next edge. After two ticks, key 6 plays with note_start=1 and no gap.
